// File: rtl/soc_system_led_pwm.sv
// Frame-synchronous LED PWM dimmer with shadowed control word.
// Define LED_PWM_BLINK_EN to add the free-running frame counter and blink blanking.
module soc_system_led_pwm #(
   parameter int unsigned PRESCALE = 195,
   parameter int unsigned NUM_LEDS = 8
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [31:0]         ctrl_word,
   output logic [NUM_LEDS-1:0] led_out,
   output logic                frame_strobe
);

`ifdef LED_PWM_BLINK_EN
   localparam int SHW = 21;
`else
   localparam int SHW = 16;
`endif

   logic [15:0]         pre_cnt;
   logic [7:0]          pwm_cnt;
   logic [SHW-1:0]      shadow;
   logic                pwm_tick;
   logic                frame_boundary;
   logic [7:0]          shadow_mask;
   logic [7:0]          shadow_duty;
   logic                blank;
   logic [NUM_LEDS-1:0] lit;
   logic                ctrl_unused;

   assign ctrl_unused    = ^ctrl_word[31:SHW];
   assign pwm_tick       = (pre_cnt == 16'(PRESCALE - 1));
   assign frame_boundary = pwm_tick && (pwm_cnt == 8'hFF);
   assign shadow_mask    = shadow[7:0];
   assign shadow_duty    = ~shadow[15:8];

`ifdef LED_PWM_BLINK_EN
   logic [15:0] frame_cnt;

   // Blink phase runs free; enabling blink never restarts it.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         frame_cnt <= '0;
      end else if (frame_boundary) begin
         frame_cnt <= frame_cnt + 16'd1;
      end
   end

   assign blank = shadow[20] & frame_cnt[shadow[19:16]];
`else
   assign blank = 1'b0;
`endif

   always_comb begin
      lit = '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
         lit[i] = shadow_mask[i] & (pwm_cnt <= shadow_duty) & ~blank;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pre_cnt      <= '0;
         pwm_cnt      <= '0;
         shadow       <= SHW'(8'h7F);
         led_out      <= '0;
         frame_strobe <= 1'b0;
      end else begin
         pre_cnt      <= pwm_tick ? 16'd0 : pre_cnt + 16'd1;
         if (pwm_tick) begin
            pwm_cnt <= pwm_cnt + 8'd1;
         end
         if (frame_boundary) begin
            shadow <= ctrl_word[SHW-1:0];
         end
         frame_strobe <= frame_boundary;
         led_out      <= lit;
      end
   end

endmodule

// File: tb/tb_soc_system_led_pwm.sv
// Bench for soc_system_led_pwm: cycle model from elapsed-time arithmetic plus directed sequences.
module tb_soc_system_led_pwm;
   localparam int P     = 2;
   localparam int N     = 8;
   localparam int FRAME = 256 * P;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic [31:0]  ctrl_word = 32'h0;
   logic [N-1:0] led_out;
   logic         frame_strobe;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   soc_system_led_pwm #(.PRESCALE(P), .NUM_LEDS(N)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .ctrl_word    (ctrl_word),
      .led_out      (led_out),
      .frame_strobe (frame_strobe)
   );

   // Reference: everything derived from t, the number of clock edges since reset release.
   int unsigned  t;
   logic [20:0]  m_shadow;
   logic [N-1:0] m_led;
   logic         m_strobe;
   logic [15:0]  m_frames;

   always @(posedge clk) begin : model
      int unsigned  pwm;
      logic         blank;
      logic [N-1:0] lit;
      logic         bnd;
      if (!reset_n) begin
         t        <= 0;
         m_shadow <= 21'h7F;
         m_led    <= '0;
         m_strobe <= 1'b0;
         m_frames <= '0;
      end else begin
         pwm = (t / P) % 256;
         bnd = ((t % FRAME) == FRAME - 1);
`ifdef LED_PWM_BLINK_EN
         blank = m_shadow[20] && m_frames[m_shadow[19:16]];
`else
         blank = 1'b0;
`endif
         for (int i = 0; i < N; i++)
            lit[i] = m_shadow[i] && (pwm <= 255 - int'(m_shadow[15:8])) && !blank;
         m_led    <= lit;
         m_strobe <= bnd;
         if (bnd) begin
            m_frames <= m_frames + 16'd1;
`ifdef LED_PWM_BLINK_EN
            m_shadow <= ctrl_word[20:0];
`else
            m_shadow <= {5'b0, ctrl_word[15:0]};
`endif
         end
         t <= t + 1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h (t=%0d)", name, act, exp, t);
      end
   endtask

   task automatic step();
      @(negedge clk);
      check("led_vs_model", 32'(led_out), 32'(m_led));
      check("strobe_vs_model", 32'(frame_strobe), 32'(m_strobe));
   endtask

   task automatic wait_strobe(input string name);
      bit seen = 0;
      for (int k = 0; k < 2 * FRAME + 8; k++) begin
         step();
         if (frame_strobe) begin
            seen = 1;
            break;
         end
      end
      check(name, 32'(seen), 32'd1);
   endtask

   typedef struct {
      logic [31:0] ctrl;
      logic [7:0]  mask;
      int          on_cycles;
   } vec_t;

   vec_t vecs[6];
   int   cnt[N];
   bit   lit_frame[8];
   int   nlit;

   initial begin
      vecs[0] = '{32'h0000BF01, 8'h01, 130};
      vecs[1] = '{32'h000000FF, 8'hFF, 512};
      vecs[2] = '{32'h0000FF03, 8'h03, 2};
      vecs[3] = '{32'h00000000, 8'h00, 0};
      vecs[4] = '{32'h0000807E, 8'h7E, 256};
      vecs[5] = '{32'hFFE000A5, 8'hA5, 512};

      // Power-on reset held for three edges.
      reset_n = 1'b0;
      repeat (3) begin
         step();
         check("reset_led", 32'(led_out), 32'h00);
         check("reset_strobe", 32'(frame_strobe), 32'd0);
      end
      reset_n = 1'b1;
      step();
      check("release_led", 32'(led_out), 32'h7F);

      // Mid-frame update must wait for the frame boundary.
      while (t < 511) begin
         step();
         if (t == 100) ctrl_word = 32'h000000FF;
         check("hold_led", 32'(led_out), 32'h7F);
         check("hold_strobe", 32'(frame_strobe), 32'd0);
      end
      step();
      check("first_strobe", 32'(frame_strobe), 32'd1);
      check("strobe_cycle_led", 32'(led_out), 32'h7F);
      step();
      check("update_led", 32'(led_out), 32'hFF);
      check("strobe_one_cycle", 32'(frame_strobe), 32'd0);

      // Duty/mask vectors: lit cycles per LED over one full frame.
      for (int v = 0; v < 6; v++) begin
         ctrl_word = vecs[v].ctrl;
         wait_strobe("vec_strobe");
         for (int i = 0; i < N; i++) cnt[i] = 0;
         for (int c = 0; c < FRAME; c++) begin
            step();
            for (int i = 0; i < N; i++) if (led_out[i]) cnt[i]++;
         end
         for (int i = 0; i < N; i++)
            check($sformatf("vec%0d_led%0d_on", v, i), 32'(cnt[i]),
                  vecs[v].mask[i] ? 32'(vecs[v].on_cycles) : 32'd0);
      end

      // Blink, rate 1: two frames lit, two blank.
      ctrl_word = 32'h00110003;
      wait_strobe("blink_strobe");
      nlit = 0;
      for (int f = 0; f < 8; f++) begin
         cnt[0] = 0;
         for (int c = 0; c < FRAME; c++) begin
            step();
            if (led_out[0] && led_out[1]) cnt[0]++;
         end
         lit_frame[f] = (cnt[0] > 0);
         if (lit_frame[f]) begin
            nlit++;
            check("blink_full_frame", 32'(cnt[0]), 32'd512);
         end
      end
`ifdef LED_PWM_BLINK_EN
      check("blink_lit_frames", 32'(nlit), 32'd4);
      for (int f = 0; f < 6; f++)
         check("blink_phase", 32'(lit_frame[f] != lit_frame[f+2]), 32'd1);
`else
      check("blink_lit_frames", 32'(nlit), 32'd8);
`endif

      // One-cycle reset at pwm step 100 restarts everything.
      ctrl_word = 32'h000000FF;
      wait_strobe("pre_reset_strobe");
      for (int k = 0; k < FRAME && ((t / P) % 256) != 100; k++) step();
      check("reached_pwm100", 32'((t / P) % 256), 32'd100);
      reset_n = 1'b0;
      step();
      check("midreset_led", 32'(led_out), 32'h00);
      check("midreset_strobe", 32'(frame_strobe), 32'd0);
      reset_n = 1'b1;
      step();
      check("midreset_release_led", 32'(led_out), 32'h7F);
      for (int k = 0; k < FRAME && t < 512; k++) step();
      check("midreset_frame_strobe", 32'(frame_strobe), 32'd1);
      step();
      check("midreset_new_led", 32'(led_out), 32'hFF);

      // ctrl_word changed on the boundary cycle itself is captured there.
      for (int k = 0; k < FRAME && (t % FRAME) != FRAME - 1; k++) step();
      ctrl_word = 32'h00000001;
      step();
      check("coinc_strobe", 32'(frame_strobe), 32'd1);
      check("coinc_old_led", 32'(led_out), 32'hFF);
      step();
      check("coinc_led", 32'(led_out), 32'h01);

      // Random control words at random times against the model.
      for (int r = 0; r < 30; r++) begin
         ctrl_word = $urandom;
         repeat ($urandom_range(1, 1200)) step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule
